// File: rtl/branch_redirect_unit.sv
// Branch/jump resolution to registered PC redirect and pipeline squash.
// Holds the redirect across stalls and keeps saturating branch statistics.
module branch_redirect_unit #(
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall_in,
   input  logic              ex_valid,
   input  logic              ex_branch,
   input  logic              conditionalS,
   input  logic              ex_jal,
   input  logic              ex_jalr,
   input  logic [ADDR_W-1:0] ex_pc,
   input  logic [ADDR_W-1:0] ex_imm,
   input  logic [ADDR_W-1:0] ex_rs1,
   output logic              pc_sel,
   output logic [ADDR_W-1:0] target_pc,
   output logic              flush_ifid,
   output logic              flush_idex,
   output logic              flush_exmem,
   output logic              misalign_exc,
   output logic [CNT_W-1:0]  branch_cnt,
   output logic [CNT_W-1:0]  taken_cnt
);

   typedef enum logic {IDLE, REDIRECT} state_t;

   state_t            state;
   state_t            next_state;
   logic              sample;
   logic              take;
   logic              cond_taken;
   logic              misalign;
   logic [ADDR_W-1:0] rel_sum;
   logic [ADDR_W-1:0] jalr_sum;
   logic [ADDR_W-1:0] target;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Resolve the EX instruction: target select (JALR > JAL > branch) and take decision.
   always_comb begin
      rel_sum    = ex_pc + ex_imm;
      jalr_sum   = ex_rs1 + ex_imm;
      target     = rel_sum;
      if (ex_jalr) begin
         target = {jalr_sum[ADDR_W-1:1], 1'b0};
      end
      sample     = (state == IDLE) && !stall_in && ex_valid;
      cond_taken = ex_branch && conditionalS;
      take       = cond_taken || ex_jal || ex_jalr;
      misalign   = target[1];
   end

   // Next-state logic: redirect on an aligned taken resolution, hold while stalled.
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: begin
            if (sample && take && !misalign) begin
               next_state = REDIRECT;
            end
         end
         REDIRECT: begin
            if (!stall_in) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Registered redirect, squash, exception pulse and latched target.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_sel       <= 1'b0;
         flush_ifid   <= 1'b0;
         flush_idex   <= 1'b0;
         flush_exmem  <= 1'b0;
         misalign_exc <= 1'b0;
         target_pc    <= '0;
      end else begin
         pc_sel       <= (next_state == REDIRECT);
         flush_ifid   <= (next_state == REDIRECT);
         flush_idex   <= (next_state == REDIRECT);
         flush_exmem  <= (next_state == REDIRECT);
         misalign_exc <= sample && take && misalign;
         if (sample && take) begin
            target_pc <= target;
         end
      end
   end

   // Saturating statistics, stepped only on sampled resolutions.
   always_ff @(posedge clk) begin
      if (reset) begin
         branch_cnt <= '0;
         taken_cnt  <= '0;
      end else if (sample) begin
         if (ex_branch && branch_cnt != CNT_MAX) begin
            branch_cnt <= branch_cnt + 1'b1;
         end
         if (cond_taken && taken_cnt != CNT_MAX) begin
            taken_cnt <= taken_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Directed bench for branch_redirect_unit (CNT_W=4 to reach saturation).
// Inputs change #1 after posedge; outputs are checked at that same point.
module tb_branch_redirect_unit;

   localparam int AW = 32;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          stall_in;
   logic          ex_valid;
   logic          ex_branch;
   logic          conditionalS;
   logic          ex_jal;
   logic          ex_jalr;
   logic [AW-1:0] ex_pc;
   logic [AW-1:0] ex_imm;
   logic [AW-1:0] ex_rs1;
   logic          pc_sel;
   logic [AW-1:0] target_pc;
   logic          flush_ifid;
   logic          flush_idex;
   logic          flush_exmem;
   logic          misalign_exc;
   logic [CW-1:0] branch_cnt;
   logic [CW-1:0] taken_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   branch_redirect_unit #(.ADDR_W(AW), .CNT_W(CW)) dut (
      .clk(clk),
      .reset(reset),
      .stall_in(stall_in),
      .ex_valid(ex_valid),
      .ex_branch(ex_branch),
      .conditionalS(conditionalS),
      .ex_jal(ex_jal),
      .ex_jalr(ex_jalr),
      .ex_pc(ex_pc),
      .ex_imm(ex_imm),
      .ex_rs1(ex_rs1),
      .pc_sel(pc_sel),
      .target_pc(target_pc),
      .flush_ifid(flush_ifid),
      .flush_idex(flush_idex),
      .flush_exmem(flush_exmem),
      .misalign_exc(misalign_exc),
      .branch_cnt(branch_cnt),
      .taken_cnt(taken_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      ex_valid     = 1'b0;
      ex_branch    = 1'b0;
      conditionalS = 1'b0;
      ex_jal       = 1'b0;
      ex_jalr      = 1'b0;
      ex_pc        = '0;
      ex_imm       = '0;
      ex_rs1       = '0;
   endtask

   task automatic br(input logic taken, input logic [AW-1:0] pc,
                     input logic [AW-1:0] imm);
      ex_valid     = 1'b1;
      ex_branch    = 1'b1;
      conditionalS = taken;
      ex_jal       = 1'b0;
      ex_jalr      = 1'b0;
      ex_pc        = pc;
      ex_imm       = imm;
   endtask

   task automatic chk_redir(input string tag, input logic v);
      chk({tag, ".pc_sel"}, 32'(pc_sel), 32'(v));
      chk({tag, ".flush"}, {29'd0, flush_ifid, flush_idex, flush_exmem},
          v ? 32'd7 : 32'd0);
   endtask

   initial begin
      reset    = 1'b1;
      stall_in = 1'b0;
      idle_in();
      step();
      step();
      reset = 1'b0;
      chk_redir("rst", 1'b0);
      chk("rst.misalign", 32'(misalign_exc), 32'd0);
      chk("rst.target", target_pc, 32'd0);
      chk("rst.bcnt", 32'(branch_cnt), 32'd0);
      chk("rst.tcnt", 32'(taken_cnt), 32'd0);

      br(1'b1, 32'h100, 32'h20);
      step();
      idle_in();
      chk_redir("beq", 1'b1);
      chk("beq.target", target_pc, 32'h120);
      chk("beq.bcnt", 32'(branch_cnt), 32'd1);
      chk("beq.tcnt", 32'(taken_cnt), 32'd1);
      step();
      chk_redir("beq.end", 1'b0);

      br(1'b0, 32'h180, 32'h40);
      step();
      idle_in();
      chk_redir("bne", 1'b0);
      chk("bne.bcnt", 32'(branch_cnt), 32'd2);
      chk("bne.tcnt", 32'(taken_cnt), 32'd1);

      ex_valid = 1'b1;
      ex_jalr  = 1'b1;
      ex_rs1   = 32'h203;
      ex_imm   = 32'h1;
      ex_pc    = 32'h500;
      step();
      idle_in();
      chk_redir("jalr", 1'b1);
      chk("jalr.target", target_pc, 32'h204);
      chk("jalr.bcnt", 32'(branch_cnt), 32'd2);
      step();

      ex_valid = 1'b1;
      ex_jal   = 1'b1;
      ex_pc    = 32'h100;
      ex_imm   = 32'h6;
      step();
      idle_in();
      chk("mis.exc", 32'(misalign_exc), 32'd1);
      chk("mis.target", target_pc, 32'h106);
      chk_redir("mis", 1'b0);
      br(1'b1, 32'h0, 32'h10);
      step();
      idle_in();
      chk("mis.pulse", 32'(misalign_exc), 32'd0);
      chk_redir("mis.idle", 1'b1);
      chk("mis.next", target_pc, 32'h10);
      chk("mis.bcnt", 32'(branch_cnt), 32'd3);
      step();

      br(1'b1, 32'h200, 32'h40);
      step();
      chk_redir("stl.c1", 1'b1);
      chk("stl.bcnt", 32'(branch_cnt), 32'd4);
      stall_in = 1'b1;
      br(1'b1, 32'h300, 32'h10);
      for (int i = 0; i < 3; i++) begin
         step();
         chk_redir($sformatf("stl.c%0d", i + 2), 1'b1);
         chk("stl.target", target_pc, 32'h240);
      end
      stall_in = 1'b0;
      step();
      idle_in();
      chk_redir("stl.end", 1'b0);
      chk("stl.target2", target_pc, 32'h240);
      chk("stl.bcnt2", 32'(branch_cnt), 32'd4);
      chk("stl.tcnt2", 32'(taken_cnt), 32'd3);

      stall_in = 1'b1;
      br(1'b1, 32'h600, 32'h8);
      step();
      step();
      stall_in = 1'b0;
      idle_in();
      chk_redir("istl", 1'b0);
      chk("istl.bcnt", 32'(branch_cnt), 32'd4);
      chk("istl.target", target_pc, 32'h240);

      br(1'b1, 32'hFFFF_FFFC, 32'h8);
      step();
      idle_in();
      chk("wrap.target", target_pc, 32'h4);
      chk_redir("wrap", 1'b1);
      step();

      for (int i = 0; i < 20; i++) begin
         br(1'b1, 32'h1000, 32'h100);
         step();
         idle_in();
         step();
      end
      chk("sat.bcnt", 32'(branch_cnt), 32'd15);
      chk("sat.tcnt", 32'(taken_cnt), 32'd15);

      br(1'b1, 32'h700, 32'h20);
      step();
      chk_redir("rmid.pre", 1'b1);
      reset = 1'b1;
      stall_in = 1'b1;
      step();
      reset = 1'b0;
      stall_in = 1'b0;
      idle_in();
      chk_redir("rmid", 1'b0);
      chk("rmid.target", target_pc, 32'd0);
      chk("rmid.bcnt", 32'(branch_cnt), 32'd0);
      chk("rmid.tcnt", 32'(taken_cnt), 32'd0);
      br(1'b1, 32'h40, 32'h10);
      step();
      idle_in();
      chk_redir("rpost", 1'b1);
      chk("rpost.target", target_pc, 32'h50);
      chk("rpost.bcnt", 32'(branch_cnt), 32'd1);
      chk("rpost.tcnt", 32'(taken_cnt), 32'd1);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/branch_redirect_unit.md
# branch_redirect_unit

Consumes the branch-taken decision produced by the condition handler in EX and turns it into a registered PC redirect plus pipeline squash for the PPU's 5-stage RISC-V pipeline (predict-not-taken). Computes the branch/jump target, checks alignment, holds the redirect across hazard stalls, and keeps saturating branch statistics. Sits between EX and the IF PC mux and the IF/ID, ID/EX and EX/MEM pipeline registers.

## Interface
- ADDR_W, 32, PC/target width
- CNT_W, 16, statistics counter width
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- stall_in  in  1  hazard-unit stall; EX and the pipeline registers hold
- ex_valid  in  1  EX holds a real, non-bubble instruction
- ex_branch  in  1  EX instruction is a conditional branch (BEQ/BNE/BLT/BGE/BLTU/BGEU)
- conditionalS  in  1  branch-taken result from the condition handler
- ex_jal  in  1  EX instruction is JAL
- ex_jalr  in  1  EX instruction is JALR
- ex_pc  in  ADDR_W  PC of the EX instruction
- ex_imm  in  ADDR_W  sign-extended immediate
- ex_rs1  in  ADDR_W  forwarded rs1 value
- pc_sel  out  1  1 = IF loads target_pc
- target_pc  out  ADDR_W  redirect target
- flush_ifid, flush_idex, flush_exmem  out  1 each  squash the named pipeline register
- misalign_exc  out  1  one-cycle pulse: taken target not 4-byte aligned
- branch_cnt, taken_cnt  out  CNT_W each  saturating statistics

## Operation
- States: IDLE, REDIRECT.
- Resolution is sampled only in IDLE with stall_in=0 and ex_valid=1. take = (ex_branch & conditionalS) | ex_jal | ex_jalr.
- Target: branch/JAL: ex_pc + ex_imm; JALR: (ex_rs1 + ex_imm) with bit 0 cleared. Additions modulo 2^ADDR_W; carry discarded.
- take=1 and target[1]=0: latch target into target_pc, go to REDIRECT.
- take=1 and target[1]=1: no redirect, stay IDLE, pulse misalign_exc for one cycle; target_pc still latched with the computed value for trap use.
- REDIRECT: pc_sel, flush_ifid, flush_idex, flush_exmem all 1. EX inputs ignored (wrong path). If stall_in=0, return to IDLE next cycle; if stall_in=1, stay in REDIRECT with all outputs and target_pc held.
- Counters, updated on sampled resolutions only: branch_cnt +1 when ex_branch=1; taken_cnt +1 when ex_branch & conditionalS. Both saturate at 2^CNT_W-1. JAL/JALR do not count. Misaligned taken branches still count.
- ex_branch with more than one of ex_branch/ex_jal/ex_jalr set: priority JALR > JAL > branch for target selection.

## Timing
- All outputs registered. Reset values: state IDLE, pc_sel=0, all flush=0, misalign_exc=0, target_pc=0, branch_cnt=0, taken_cnt=0.
- Latency: resolution sampled at edge ending cycle N -> pc_sel/flush asserted throughout cycle N+1; IF fetches target in cycle N+2.
- Redirect window is exactly one cycle when stall_in=0 in N+1; extends one cycle per stalled cycle.
- Back-to-back: a taken branch in EX during REDIRECT is wrong-path and is never sampled or counted.
- stall_in=1 in IDLE: no sampling, no counting, outputs stay 0.
- reset asserted in any state (including mid-REDIRECT or mid-stall): next cycle all outputs at reset values; counters cleared.

## Test plan
- BEQ taken: ex_pc=0x100, ex_imm=0x20, ex_branch=1, conditionalS=1 -> next cycle pc_sel=1, target_pc=0x120, three flushes=1 for one cycle; branch_cnt=1, taken_cnt=1.
- BNE not taken (conditionalS=0) -> pc_sel stays 0, branch_cnt=1, taken_cnt=0; JALR with rs1=0x203, imm=0x1 -> target_pc=0x204, redirect.
- Misaligned: JAL ex_pc=0x100, ex_imm=0x6 -> misalign_exc one-cycle pulse, target_pc=0x106, pc_sel=0, state IDLE.
- Stall during REDIRECT: stall_in=1 for 3 cycles after taken branch -> pc_sel/flushes held 4 cycles, target unchanged; taken branch presented in EX meanwhile is not counted.
- Saturation and wrap: CNT_W=4, 20 taken branches -> both counters 15; ex_pc=0xFFFFFFFC, ex_imm=0x8 -> target_pc=0x00000004.
- Reset mid-REDIRECT -> next cycle all outputs 0, counters 0, next valid branch handled normally.
